div_radix2: RTL and testbench

Multi-cycle radix-2 restoring integer divider for the MIPS HI/LO unit. It is instantiated by the alpha-pipeline ALU, which owns all HI/LO writes, and produces the 64-bit `{remainder, quotient}` value committed by DIV/DIVU. The ALU starts a division by presenting a non-zero `div_op` while `done` is high. It commits `result` on the rising edge of `done`.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/div_radix2.sv | 197 +++++++++++++++++++
 tb/tb_div_radix2.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//   Definitions shared by the multiply/divide unit blocks (divider and
//   multiplier) that feed the MIPS HI/LO registers.
//
//   Contents:
//     DIV_OP_*     encodings of the divider's 2-bit div_op request
//     div_state_t  divider control states
//     DIV_ITERS    quotient bits produced, one per CALC cycle
//     mag32/neg32  helpers for turning signed operands into magnitudes and back
// -----------------------------------------------------------------------------
package mdu_pkg;

  // div_op request encodings. 2'b11 is not a request and is treated like NONE.
  localparam logic [1:0] DIV_OP_NONE = 2'b00;
  localparam logic [1:0] DIV_OP_U    = 2'b01;
  localparam logic [1:0] DIV_OP_S    = 2'b10;

  // One quotient bit is retired per CALC cycle.
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Two's complement negate, 32 bits, wrapping.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Unsigned magnitude of a signed 32-bit value. 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// -----------------------------------------------------------------------------
// div_radix2
//   Multi-cycle radix-2 restoring integer divider for the MIPS HI/LO unit.
//   Produces the {remainder, quotient} image committed by DIV/DIVU. The owning
//   ALU starts a division by presenting a request while done is high and
//   commits result on the rising edge of done.
//
//   A signed division is performed on unsigned magnitudes; the signs of the
//   quotient and remainder are restored in a single FIX cycle after the 32
//   shift/subtract iterations. Divide-by-zero returns quotient all-ones and
//   the original dividend as remainder for both signed and unsigned requests.
//
//   Ports:
//     clk       in   1   system clock
//     rst       in   1   synchronous active-high reset
//     div_op    in   2   2'b10 signed DIV, 2'b01 unsigned DIVU, else no request
//     dividend  in  32   rs operand, sampled only on the accept edge
//     divisor   in  32   rt operand, sampled only on the accept edge
//     result    out 64   {remainder, quotient} (HI:LO image), registered
//     done      out  1   high when idle/finished, low while dividing
//
//   Timing: accept on edge E0, CALC on E1..E32, FIX on E33. done is low for
//   exactly 33 cycles and a new request is accepted on the first edge after
//   done returns high.
// -----------------------------------------------------------------------------
module div_radix2
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  div_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [63:0] result,
  output logic        done
);

  localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  div_state_t  state_reg, state_next;

  logic [5:0]  cnt_reg;          // iteration counter, 0..31 during CALC
  logic [32:0] rem_reg;          // partial remainder
  logic [31:0] quo_reg;          // dividend magnitude shifting out, quotient in
  logic [31:0] dvsr_mag_reg;     // divisor magnitude
  logic [31:0] dividend_reg;     // dividend as presented, for divide-by-zero
  logic        neg_q_reg;        // quotient must be negated in FIX
  logic        neg_r_reg;        // remainder must be negated in FIX
  logic        div_zero_reg;     // divisor was zero
  logic [63:0] result_reg;

  // Control decode
  logic        accept;
  logic        req_valid;

  // One shift/subtract step
  logic [33:0] rem_shift;
  logic [33:0] trial;
  logic [32:0] rem_step;
  logic [31:0] quo_step;

  // Sign fix-up
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign req_valid = (div_op == DIV_OP_U) || (div_op == DIV_OP_S);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs. done decodes the state register only, so no
  // input reaches an output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        done = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (cnt_reg == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restoring step: shift {rem, quo} left one bit, try subtracting the
  // divisor, keep the difference and set the quotient bit if it did not go
  // negative. The partial remainder is always below the divisor, so the
  // shifted value fits in 33 bits; the extra top bit of the subtraction just
  // carries the borrow.
  // ---------------------------------------------------------------------------
  always_comb begin
    rem_shift = {rem_reg, quo_reg[31]};
    trial     = rem_shift - {2'b00, dvsr_mag_reg};
    quo_step  = {quo_reg[30:0], 1'b0};
    rem_step  = rem_shift[32:0];
    if (!trial[33]) begin
      rem_step    = trial[32:0];
      quo_step[0] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sign restoration and divide-by-zero override for the FIX cycle.
  // The signed overflow case -2^31 / -1 has both signs negative, so the
  // magnitude quotient 0x8000_0000 is passed through unnegated and wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (div_zero_reg) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = dividend_reg;
    end else begin
      q_fix = neg_q_reg ? neg32(quo_reg)       : quo_reg;
      r_fix = neg_r_reg ? neg32(rem_reg[31:0]) : rem_reg[31:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= 6'd0;
      rem_reg      <= 33'd0;
      quo_reg      <= 32'd0;
      dvsr_mag_reg <= 32'd0;
      dividend_reg <= 32'd0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      result_reg   <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cnt_reg      <= 6'd0;
            rem_reg      <= 33'd0;
            dividend_reg <= dividend;
            div_zero_reg <= (divisor == 32'd0);
            if (div_op == DIV_OP_S) begin
              quo_reg      <= mag32(dividend);
              dvsr_mag_reg <= mag32(divisor);
              neg_q_reg    <= dividend[31] ^ divisor[31];
              neg_r_reg    <= dividend[31];
            end else begin
              quo_reg      <= dividend;
              dvsr_mag_reg <= divisor;
              neg_q_reg    <= 1'b0;
              neg_r_reg    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + 6'd1;
        end
        FIX: begin
          result_reg <= {r_fix, q_fix};
        end
        default: begin
          cnt_reg <= 6'd0;
        end
      endcase
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_div_radix2
//   Scoreboard bench for div_radix2. The stimulus process issues directed
//   divisions and pushes hand-computed {remainder, quotient} values into a
//   queue; a monitor pops and compares on every rising edge of done and also
//   checks that done was low for 33 cycles.
// -----------------------------------------------------------------------------
module tb_div_radix2;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [63:0] result;
  logic        done;

  always #5 clk = ~clk;

  div_radix2 dut (
    .clk      (clk),
    .rst      (rst),
    .div_op   (div_op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done)
  );

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares result on each rising edge of done.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic        done_prev;
    int          low_cnt;
    logic [63:0] e;
    string       nm;
    done_prev = 1'b1;
    low_cnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_prev = 1'b1;
        low_cnt   = 0;
      end else begin
        if (!done) begin
          low_cnt++;
        end else if (!done_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL stray_done_edge: done rose with no pending division, result %h", result);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, result, e);
            check({nm, "_latency"}, 64'(low_cnt), 64'd33);
            $display("txn %s: result=%h expected=%h done_low=%0d", nm, result, e, low_cnt);
          end
          low_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        checks++;
        $display("FAIL %s_timeout: done still %b after %0d cycles, required 1", nm, done, n);
        break;
      end
    end
  endtask

  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm, input bit garble);
    int n;
    wait_idle(nm);
    div_op   = op;
    dividend = a;
    divisor  = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    div_op = DIV_OP_NONE;
    check({nm, "_accept"}, 64'(done), 64'd0);
    if (garble) begin
      n = 0;
      while (done === 1'b0 && n < 60) begin
        div_op   = 2'($urandom_range(0, 3));
        dividend = $urandom;
        divisor  = $urandom;
        @(negedge clk);
        n++;
      end
      div_op = DIV_OP_NONE;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    rst      = 1'b1;
    div_op   = DIV_OP_NONE;
    dividend = 32'd0;
    divisor  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset_done", 64'(done), 64'd1);
    check("reset_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(DIV_OP_U, 32'd100, 32'd7, {32'd2, 32'd14}, "u_100_div_7", 1'b0);
    run_div(DIV_OP_S, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_div_2", 1'b0);
    run_div(DIV_OP_S, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "s_7_div_m2", 1'b0);
    run_div(DIV_OP_S, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, "s_m7_div_m2", 1'b0);
    run_div(DIV_OP_S, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, "s_overflow", 1'b0);
    run_div(DIV_OP_U, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, "u_max_div_1", 1'b0);
    run_div(DIV_OP_U, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, "u_div_zero", 1'b0);
    run_div(DIV_OP_S, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, "s_div_zero", 1'b0);
    run_div(DIV_OP_S, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "s_neg_div_zero", 1'b0);
    run_div(DIV_OP_S, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "s_m100_div_7", 1'b0);
    run_div(DIV_OP_U, 32'hFFFF_FF9C, 32'd7, {32'h0000_0002, 32'h2492_4916}, "u_big_div_7", 1'b0);

    // Inputs churn every cycle while busy; next request lands on E34.
    run_div(DIV_OP_U, 32'd1000, 32'd10, {32'd0, 32'd100}, "busy_garble", 1'b1);
    run_div(DIV_OP_U, 32'd17, 32'd5, {32'd2, 32'd3}, "back_to_back", 1'b0);

    // div_op = 11 is not a request.
    wait_idle("op11");
    div_op   = 2'b11;
    dividend = 32'd50;
    divisor  = 32'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("op11_done", 64'(done), 64'd1);
      check("op11_result", result, {32'd2, 32'd3});
    end
    div_op = DIV_OP_NONE;

    // Abort mid-CALC with reset on the 10th cycle.
    run_div(DIV_OP_U, 32'hFFFF_0000, 32'd3, 64'd0, "aborted", 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    name_q.delete();
    @(negedge clk);
    check("abort_done", 64'(done), 64'd1);
    check("abort_result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_idle_done", 64'(done), 64'd1);

    run_div(DIV_OP_U, 32'd9, 32'd3, {32'd0, 32'd3}, "after_reset", 1'b0);
    wait_idle("final");
    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
